// File: rtl/fft_peak_detect.sv
// fft_peak_detect: streaming peak finder that runs after the 128-point FFT.
// Each bin's power re^2+im^2 goes through a three-stage pipeline. For every
// frame it reports the bin with the largest power, that power, and a
// saturating count of completed frames. A frame cut short by din_done is
// dropped, and partial pulses once to show this.
//
// Handshake: din_valid qualifies din_re/din_im in the same cycle. There is no
// ready, so the block consumes every valid beat in the cycle it appears.
module fft_peak_detect #(
    parameter int WIDTH   = 16,
    parameter int N       = 128,
    parameter int LOG2N   = 7,
    parameter int POW_W   = 33,
    parameter int SKIP_DC = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic signed [WIDTH-1:0] din_re,
    input  logic signed [WIDTH-1:0] din_im,
    input  logic                    din_valid,
    input  logic                    din_done,
    output logic [LOG2N-1:0]        peak_bin,
    output logic [POW_W-1:0]        peak_pow,
    output logic                    frame_valid,
    output logic [15:0]             frame_count,
    output logic                    partial,
    output logic                    busy,
    output logic                    state_dbg
);

    localparam logic [LOG2N-1:0] LAST_BIN  = LOG2N'(N - 1);
    localparam logic [LOG2N-1:0] FIRST_BIN = LOG2N'((SKIP_DC != 0) ? 1 : 0);
    localparam logic             SKIP      = (SKIP_DC != 0);

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [LOG2N-1:0] bin_cnt, cnt_after, cnt_nxt;
    logic             in_last;
    logic             abort;
    logic             a_load;

    // Stage A: squared components plus per-bin tags
    logic                 a_valid, a_first, a_last, a_use;
    logic [2*WIDTH-1:0]   a_re2, a_im2;
    logic [LOG2N-1:0]     a_bin;
    // Stage B: summed power
    logic                 b_valid, b_first, b_last, b_use;
    logic [POW_W-1:0]     b_pow;
    logic [LOG2N-1:0]     b_bin;
    // Stage C: running max
    logic                 c_valid;
    logic [POW_W-1:0]     max_pow;
    logic [LOG2N-1:0]     max_bin;

    logic                 kill_a, kill_b, c_take, c_upd;
    logic signed [2*WIDTH-1:0] re_ext, im_ext, re_sq, im_sq;

    // Bin counter look-ahead and end-of-stream abort decision
    always_comb begin
        in_last   = (bin_cnt == LAST_BIN);
        cnt_after = bin_cnt;
        if (din_valid) begin
            cnt_after = in_last ? '0 : bin_cnt + LOG2N'(1);
        end
        abort   = din_done && (cnt_after != '0);
        cnt_nxt = abort ? '0 : cnt_after;
        a_load  = din_valid && !abort;
        // Pipeline entries older than a last-bin tag belong to the previous,
        // already completed frame and must survive an abort.
        kill_a  = abort && !(a_valid && a_last);
        kill_b  = kill_a && !(b_valid && b_last);
        c_take  = b_valid && !kill_b;
        c_upd   = c_take && b_use && (b_first || (b_pow > max_pow));
    end

    // Sign-extended squares; both products are non-negative
    always_comb begin
        re_ext = {{WIDTH{din_re[WIDTH-1]}}, din_re};
        im_ext = {{WIDTH{din_im[WIDTH-1]}}, din_im};
        re_sq  = re_ext * re_ext;
        im_sq  = im_ext * im_ext;
    end

    // FSM next state: IDLE means the counter is at zero
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (din_valid && !abort && !in_last) state_nxt = ACC;
            ACC:  if (abort || (din_valid && in_last)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register and bin counter
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            bin_cnt <= '0;
        end else begin
            state   <= state_nxt;
            bin_cnt <= cnt_nxt;
        end
    end

    // Stage A: register the squares and the bin tags
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            a_valid <= 1'b0;
            a_re2   <= '0;
            a_im2   <= '0;
            a_bin   <= '0;
            a_first <= 1'b0;
            a_last  <= 1'b0;
            a_use   <= 1'b0;
        end else begin
            a_valid <= a_load;
            a_re2   <= re_sq;
            a_im2   <= im_sq;
            a_bin   <= bin_cnt;
            a_first <= (bin_cnt == FIRST_BIN);
            a_last  <= in_last;
            a_use   <= !(SKIP && (bin_cnt == '0));
        end
    end

    // Stage B: zero-extended power sum
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            b_valid <= 1'b0;
            b_pow   <= '0;
            b_bin   <= '0;
            b_first <= 1'b0;
            b_last  <= 1'b0;
            b_use   <= 1'b0;
        end else begin
            b_valid <= a_valid && !kill_a;
            b_pow   <= POW_W'({1'b0, a_re2}) + POW_W'({1'b0, a_im2});
            b_bin   <= a_bin;
            b_first <= a_first;
            b_last  <= a_last;
            b_use   <= a_use;
        end
    end

    // Stage C: running max and result load on the last bin of a frame
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            c_valid     <= 1'b0;
            max_pow     <= '0;
            max_bin     <= '0;
            peak_bin    <= '0;
            peak_pow    <= '0;
            frame_valid <= 1'b0;
            frame_count <= '0;
        end else begin
            c_valid     <= c_take;
            frame_valid <= 1'b0;
            if (c_upd) begin
                max_pow <= b_pow;
                max_bin <= b_bin;
            end
            if (c_take && b_last) begin
                // Results come from the comparison itself, so a new frame's
                // first bin arriving next cycle cannot disturb them.
                peak_pow    <= c_upd ? b_pow : max_pow;
                peak_bin    <= c_upd ? b_bin : max_bin;
                frame_valid <= 1'b1;
                if (frame_count != 16'hFFFF) begin
                    frame_count <= frame_count + 16'd1;
                end
            end
        end
    end

    // Partial-frame pulse, one cycle after the abort
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            partial <= 1'b0;
        end else begin
            partial <= abort;
        end
    end

    // Busy while accumulating or while anything is in flight
    always_comb begin
        busy      = (state == ACC) || a_valid || b_valid || c_valid;
        state_dbg = (state == ACC);
    end

endmodule

// File: tb/tb_fft_peak_detect.sv
// Bench for fft_peak_detect. Two instances share the stimulus: one with
// SKIP_DC=1 and one with SKIP_DC=0. A behavioural argmax model fills the
// expected queues, and a negedge monitor pops them.
module tb_fft_peak_detect;

  localparam int N  = 128;
  localparam int EW = 88;  // {cycle[31:0], count[15:0], bin[6:0], pow[32:0]}

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic signed [15:0] din_re = '0;
  logic signed [15:0] din_im = '0;
  logic din_valid = 1'b0;
  logic din_done  = 1'b0;

  logic [6:0]  peak_bin, nd_peak_bin;
  logic [32:0] peak_pow, nd_peak_pow;
  logic        frame_valid, nd_frame_valid;
  logic [15:0] frame_count, nd_frame_count;
  logic        partial, nd_partial, busy, nd_busy, state_dbg, nd_state_dbg;

  fft_peak_detect #(.SKIP_DC(1)) dut (
    .clock(clock), .reset(reset), .din_re(din_re), .din_im(din_im),
    .din_valid(din_valid), .din_done(din_done), .peak_bin(peak_bin),
    .peak_pow(peak_pow), .frame_valid(frame_valid), .frame_count(frame_count),
    .partial(partial), .busy(busy), .state_dbg(state_dbg)
  );

  fft_peak_detect #(.SKIP_DC(0)) dut_nd (
    .clock(clock), .reset(reset), .din_re(din_re), .din_im(din_im),
    .din_valid(din_valid), .din_done(din_done), .peak_bin(nd_peak_bin),
    .peak_pow(nd_peak_pow), .frame_valid(nd_frame_valid), .frame_count(nd_frame_count),
    .partial(nd_partial), .busy(nd_busy), .state_dbg(nd_state_dbg)
  );

  // scoreboard
  int n_checks = 0;
  int n_err    = 0;
  int re_v[N];
  int im_v[N];
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp_nd_q[$];
  logic [EW-1:0] part_q[$];
  logic [EW-1:0] part_nd_q[$];
  int exp_fc = 0;
  logic [6:0]  last_bin = '0, last_bin_nd = '0;
  logic [32:0] last_pow = '0, last_pow_nd = '0;
  logic [EW-1:0] mon_e;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // argmax of power with strict-greater replacement (ties keep lowest index)
  function automatic logic [39:0] model_peak(input bit skip);
    longint best = 0;
    int     bb = 0;
    bit     first = 1'b1;
    for (int b = (skip ? 1 : 0); b < N; b++) begin
      longint p = longint'(re_v[b]) * re_v[b] + longint'(im_v[b]) * im_v[b];
      if (first || p > best) begin
        best  = p;
        bb    = b;
        first = 1'b0;
      end
    end
    return {bb[6:0], best[32:0]};
  endfunction

  // driver tasks (all start and end at posedge + #1)
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic drive_bin(input int b);
    logic [39:0] m;
    din_re    = 16'(re_v[b]);
    din_im    = 16'(im_v[b]);
    din_valid = 1'b1;
    if (b == N - 1) begin
      if (exp_fc != 65535) exp_fc++;
      m = model_peak(1'b1);
      exp_q.push_back({32'(cyc + 3), 16'(exp_fc), m});
      last_bin = m[39:33];
      last_pow = m[32:0];
      m = model_peak(1'b0);
      exp_nd_q.push_back({32'(cyc + 3), 16'(exp_fc), m});
      last_bin_nd = m[39:33];
      last_pow_nd = m[32:0];
    end
    @(posedge clock);
    #1;
    din_valid = 1'b0;
  endtask

  task automatic drive_range(input int lo, input int hi, input int gapmax);
    for (int b = lo; b <= hi; b++) begin
      idle($urandom_range(0, gapmax));
      drive_bin(b);
    end
  endtask

  task automatic send_done();
    din_done = 1'b1;
    part_q.push_back({32'(cyc + 1), 16'(exp_fc), last_bin, last_pow});
    part_nd_q.push_back({32'(cyc + 1), 16'(exp_fc), last_bin_nd, last_pow_nd});
    @(posedge clock);
    #1;
    din_done = 1'b0;
  endtask

  task automatic fill(input int val_re, input int val_im);
    for (int b = 0; b < N; b++) begin
      re_v[b] = val_re;
      im_v[b] = val_im;
    end
  endtask

  task automatic fill_rand();
    for (int b = 0; b < N; b++) begin
      re_v[b] = int'($urandom_range(0, 200)) - 100;
      im_v[b] = int'($urandom_range(0, 200)) - 100;
    end
  endtask

  // monitor: compare outputs against popped expectations
  always @(negedge clock) begin
    if (reset) begin
      if (frame_valid) begin
        if (exp_q.size() == 0) check("fv_unexpected", 64'(1), 64'(0));
        else begin
          mon_e = exp_q.pop_front();
          check("fv_cycle", 64'(cyc), 64'(mon_e[87:56]));
          check("frame_count", 64'(frame_count), 64'(mon_e[55:40]));
          check("peak_bin", 64'(peak_bin), 64'(mon_e[39:33]));
          check("peak_pow", 64'(peak_pow), 64'(mon_e[32:0]));
        end
      end
      if (nd_frame_valid) begin
        if (exp_nd_q.size() == 0) check("nd_fv_unexpected", 64'(1), 64'(0));
        else begin
          mon_e = exp_nd_q.pop_front();
          check("nd_fv_cycle", 64'(cyc), 64'(mon_e[87:56]));
          check("nd_frame_count", 64'(nd_frame_count), 64'(mon_e[55:40]));
          check("nd_peak_bin", 64'(nd_peak_bin), 64'(mon_e[39:33]));
          check("nd_peak_pow", 64'(nd_peak_pow), 64'(mon_e[32:0]));
        end
      end
      if (partial) begin
        if (part_q.size() == 0) check("partial_unexpected", 64'(1), 64'(0));
        else begin
          mon_e = part_q.pop_front();
          check("partial_cycle", 64'(cyc), 64'(mon_e[87:56]));
          check("partial_count_hold", 64'(frame_count), 64'(mon_e[55:40]));
          check("partial_bin_hold", 64'(peak_bin), 64'(mon_e[39:33]));
          check("partial_pow_hold", 64'(peak_pow), 64'(mon_e[32:0]));
        end
      end
      if (nd_partial) begin
        if (part_nd_q.size() == 0) check("nd_partial_unexpected", 64'(1), 64'(0));
        else begin
          mon_e = part_nd_q.pop_front();
          check("nd_partial_cycle", 64'(cyc), 64'(mon_e[87:56]));
          check("nd_partial_bin_hold", 64'(nd_peak_bin), 64'(mon_e[39:33]));
        end
      end
    end
  end

  // stimulus
  initial begin
    idle(3);
    check("rst_peak_bin", 64'(peak_bin), 64'(0));
    check("rst_peak_pow", 64'(peak_pow), 64'(0));
    check("rst_frame_valid", 64'(frame_valid), 64'(0));
    check("rst_frame_count", 64'(frame_count), 64'(0));
    check("rst_partial", 64'(partial), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    reset = 1'b1;
    idle(2);

    // single tone
    fill(0, 0);
    re_v[37] = 1000;
    drive_range(0, N - 1, 0);
    idle(6);
    check("tone_bin", 64'(peak_bin), 64'(37));
    check("tone_pow", 64'(peak_pow), 64'(1000000));
    check("tone_busy_done", 64'(busy), 64'(0));

    // full scale, DC excluded vs included
    fill(1, 1);
    re_v[0] = -32768; im_v[0] = -32768;
    re_v[90] = -32768; im_v[90] = -32768;
    drive_range(0, N - 1, 0);
    idle(6);
    check("fs_bin", 64'(peak_bin), 64'(90));
    check("fs_pow", 64'(peak_pow), 64'(33'h1_0000_0000 >> 1));
    check("fs_nd_bin", 64'(nd_peak_bin), 64'(0));

    // tie with random gaps
    fill(0, 0);
    re_v[10] = 300; im_v[10] = -400;
    re_v[20] = 300; im_v[20] = -400;
    drive_range(0, N - 1, 3);
    idle(6);
    check("tie_bin", 64'(peak_bin), 64'(10));
    check("tie_pow", 64'(peak_pow), 64'(250000));

    // back-to-back frames, no gaps
    fill_rand();
    re_v[5] = 2000; im_v[5] = 0;
    drive_range(0, N - 1, 0);
    fill_rand();
    re_v[120] = 2000; im_v[120] = 0;
    drive_range(0, N - 1, 0);
    idle(6);
    check("b2b_bin", 64'(peak_bin), 64'(120));
    check("b2b_count", 64'(frame_count), 64'(5));

    // partial frame then a full frame
    fill_rand();
    drive_range(0, 59, 0);
    check("acc_busy", 64'(busy), 64'(1));
    send_done();
    idle(6);
    check("partial_busy_clear", 64'(busy), 64'(0));
    fill_rand();
    re_v[77] = -3000; im_v[77] = 100;
    drive_range(0, N - 1, 1);
    idle(6);
    check("after_partial_bin", 64'(peak_bin), 64'(77));

    // done while idle has no effect
    din_done = 1'b1;
    idle(2);
    din_done = 1'b0;

    // reset mid-frame
    fill_rand();
    drive_range(0, 69, 0);
    reset = 1'b0;
    #1;
    check("mrst_peak_bin", 64'(peak_bin), 64'(0));
    check("mrst_peak_pow", 64'(peak_pow), 64'(0));
    check("mrst_frame_count", 64'(frame_count), 64'(0));
    check("mrst_busy", 64'(busy), 64'(0));
    check("mrst_state", 64'(state_dbg), 64'(0));
    exp_fc = 0;
    last_bin = '0; last_pow = '0; last_bin_nd = '0; last_pow_nd = '0;
    idle(2);
    reset = 1'b1;
    idle(1);
    fill_rand();
    re_v[3] = 1500; im_v[3] = -1500;
    drive_range(0, N - 1, 0);
    idle(6);
    check("post_rst_count", 64'(frame_count), 64'(1));
    check("post_rst_bin", 64'(peak_bin), 64'(3));

    // random frames
    for (int f = 0; f < 3; f++) begin
      fill_rand();
      drive_range(0, N - 1, 2);
    end
    idle(8);

    check("exp_q_empty", 64'(exp_q.size()), 64'(0));
    check("exp_nd_q_empty", 64'(exp_nd_q.size()), 64'(0));
    check("part_q_empty", 64'(part_q.size()), 64'(0));
    check("part_nd_q_empty", 64'(part_nd_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
